// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU control, forwarding selects,
// R-type funct codes and the multiply/divide unit's op and state types.
package ex_pkg;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_OR    = 2'b11;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Order matches funct[1:0] of mult/multu/div/divu.
  typedef enum logic [1:0] {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU} mdu_op_e;

  typedef enum logic [1:0] {MDU_IDLE, MDU_RUN, MDU_DONE} mdu_state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit with HI/LO. Works on operand
// magnitudes and applies sign correction on the final iteration.
module mdu_iter
  import ex_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = $clog2(DATA_W);

  // Handshake: start is a one-cycle request honoured only in IDLE; busy is
  // high for the DATA_W iterations and done pulses for one cycle once HI/LO
  // hold the new result. start is ignored while busy or done.
  mdu_state_e        state;
  mdu_op_e           op_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc_hi, acc_lo, opnd_b, a_raw;
  logic              res_neg, rem_neg, div_zero;

  mdu_op_e           op_in;
  logic              in_signed, in_div, a_neg, b_neg, is_div;
  logic [DATA_W-1:0] mag_a, mag_b;

  assign op_in     = mdu_op_e'(op);
  assign in_signed = (op_in == MDU_MULT) || (op_in == MDU_DIV);
  assign in_div    = (op_in == MDU_DIV) || (op_in == MDU_DIVU);
  assign a_neg     = in_signed & a[DATA_W-1];
  assign b_neg     = in_signed & b[DATA_W-1];
  assign mag_a     = a_neg ? -a : a;
  assign mag_b     = b_neg ? -b : b;
  assign is_div    = (op_q == MDU_DIV) || (op_q == MDU_DIVU);

  logic [DATA_W:0]     mul_sum, div_shift, div_diff;
  logic [DATA_W-1:0]   step_hi, step_lo, fin_hi, fin_lo;
  logic [2*DATA_W-1:0] prod, prod_fix;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
  assign div_shift = {acc_hi, acc_lo[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, opnd_b};

  // acc_hi is the partial product / partial remainder; acc_lo the
  // multiplier being shifted out / the quotient being shifted in.
  always_comb begin
    step_hi = acc_hi;
    step_lo = acc_lo;
    if (is_div) begin
      if (!div_diff[DATA_W]) begin
        step_hi = div_diff[DATA_W-1:0];
        step_lo = {acc_lo[DATA_W-2:0], 1'b1};
      end else begin
        step_hi = div_shift[DATA_W-1:0];
        step_lo = {acc_lo[DATA_W-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[DATA_W:1];
      step_lo = {mul_sum[0], acc_lo[DATA_W-1:1]};
    end
  end

  assign prod     = {step_hi, step_lo};
  assign prod_fix = res_neg ? -prod : prod;

  always_comb begin
    fin_hi = prod_fix[2*DATA_W-1:DATA_W];
    fin_lo = prod_fix[DATA_W-1:0];
    if (is_div) begin
      if (div_zero) begin
        fin_hi = a_raw;
        fin_lo = {DATA_W{1'b1}};
      end else begin
        fin_hi = rem_neg ? -step_hi : step_hi;
        fin_lo = res_neg ? -step_lo : step_lo;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= MDU_IDLE;
      op_q     <= MDU_MULT;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd_b   <= '0;
      a_raw    <= '0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (start) begin
            state    <= MDU_RUN;
            busy     <= 1'b1;
            cnt      <= '0;
            op_q     <= op_in;
            a_raw    <= a;
            res_neg  <= a_neg ^ b_neg;
            rem_neg  <= a_neg;
            div_zero <= (b == '0);
            acc_hi   <= '0;
            acc_lo   <= in_div ? mag_a : mag_b;
            opnd_b   <= in_div ? mag_b : mag_a;
          end
        end
        MDU_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            hi    <= fin_hi;
            lo    <= fin_lo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= MDU_DONE;
          end
        end
        MDU_DONE: begin
          done  <= 1'b0;
          state <= MDU_IDLE;
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: rtl/ex_pipe_stage_mdu.sv
// MIPS execute stage: operand forwarding, ALU-source mux, ALU with funct
// decode, and the multi-cycle multiply/divide unit that stalls the front end.
module ex_pipe_stage_mdu
  import ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_ex_valid,
  input  logic [31:0]       id_ex_instr,
  input  logic [DATA_W-1:0] id_ex_reg1,
  input  logic [DATA_W-1:0] id_ex_reg2,
  input  logic [DATA_W-1:0] id_ex_imm_value,
  input  logic              id_ex_alu_src,
  input  logic [1:0]        id_ex_alu_op,
  input  logic [DATA_W-1:0] ex_mem_alu_result,
  input  logic [DATA_W-1:0] mem_wb_write_back_result,
  input  logic [1:0]        forward_a,
  input  logic [1:0]        forward_b,
  output logic [DATA_W-1:0] alu_in2_out,
  output logic [DATA_W-1:0] alu_result,
  output logic              alu_zero,
  output logic              alu_overflow,
  output logic              ex_stall,
  output logic              mdu_busy
);

  logic [5:0]        funct;
  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] op_a, fwd_b, op_b, sum, diff, mdu_hi, mdu_lo;
  logic              is_mdu_fn, start_req, mdu_done;
  logic [1:0]        mdu_state;
  logic              unused_instr;

  assign funct        = id_ex_instr[5:0];
  assign shamt        = id_ex_instr[6 +: SH_W];
  assign unused_instr = ^id_ex_instr[31:11];

  always_comb begin
    case (forward_a)
      FWD_WB:  op_a = mem_wb_write_back_result;
      FWD_MEM: op_a = ex_mem_alu_result;
      default: op_a = id_ex_reg1;
    endcase
    case (forward_b)
      FWD_WB:  fwd_b = mem_wb_write_back_result;
      FWD_MEM: fwd_b = ex_mem_alu_result;
      default: fwd_b = id_ex_reg2;
    endcase
  end

  assign op_b        = id_ex_alu_src ? id_ex_imm_value : fwd_b;
  assign alu_in2_out = fwd_b;
  assign sum         = op_a + op_b;
  assign diff        = op_a - op_b;

  always_comb begin
    alu_result   = '0;
    alu_overflow = 1'b0;
    case (id_ex_alu_op)
      ALU_OP_ADD: alu_result = sum;
      ALU_OP_SUB: alu_result = diff;
      ALU_OP_OR:  alu_result = op_a | op_b;
      default: begin
        case (funct)
          FN_ADD, FN_ADDU: begin
            alu_result   = sum;
            alu_overflow = (funct == FN_ADD) && (op_a[DATA_W-1] == op_b[DATA_W-1])
                           && (sum[DATA_W-1] != op_a[DATA_W-1]);
          end
          FN_SUB, FN_SUBU: begin
            alu_result   = diff;
            alu_overflow = (funct == FN_SUB) && (op_a[DATA_W-1] != op_b[DATA_W-1])
                           && (diff[DATA_W-1] != op_a[DATA_W-1]);
          end
          FN_AND:  alu_result = op_a & op_b;
          FN_OR:   alu_result = op_a | op_b;
          FN_XOR:  alu_result = op_a ^ op_b;
          FN_NOR:  alu_result = ~(op_a | op_b);
          FN_SLT:  alu_result = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
          FN_SLTU: alu_result = {{(DATA_W-1){1'b0}}, op_a < op_b};
          FN_SLL:  alu_result = op_b << shamt;
          FN_SRL:  alu_result = op_b >> shamt;
          FN_SRA:  alu_result = $signed(op_b) >>> shamt;
          FN_MFHI: alu_result = mdu_hi;
          FN_MFLO: alu_result = mdu_lo;
          default: alu_result = '0;
        endcase
      end
    endcase
  end

  assign alu_zero = (alu_result == '0);

  // A DONE-cycle instruction is still the finished mult/div; done blocks its restart.
  assign is_mdu_fn = (funct == FN_MULT) || (funct == FN_MULTU) ||
                     (funct == FN_DIV)  || (funct == FN_DIVU);
  assign start_req = id_ex_valid && (id_ex_alu_op == ALU_OP_RTYPE) && is_mdu_fn &&
                     !mdu_busy && !mdu_done && (mdu_state == MDU_IDLE);
  assign ex_stall  = start_req | mdu_busy;

  mdu_iter #(.DATA_W(DATA_W)) u_mdu (
    .clk       (clk),
    .reset     (reset),
    .start     (start_req),
    .op        (funct[1:0]),
    .a         (op_a),
    .b         (fwd_b),
    .busy      (mdu_busy),
    .done      (mdu_done),
    .hi        (mdu_hi),
    .lo        (mdu_lo),
    .state_dbg (mdu_state)
  );

endmodule

// File: doc/ex_pipe_stage_mdu.md
Name: ex_pipe_stage_mdu

Overview:
- Parametrised execute stage for the MIPS pipeline: forwarding muxes, ALU-source mux, full R-type/I-type ALU with integrated ALU control, and an iterative multiply/divide unit (MDU) with HI/LO registers.
- Sits between the ID/EX and EX/MEM registers.
- Multi-cycle MDU operations stall the front of the pipeline through ex_stall.

Parameters:
- DATA_W, 32: datapath width. Must be ≥8 and a power of two.
- SH_W, $clog2(DATA_W): shift-amount width, derived; do not override.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- id_ex_valid  in  1  ID/EX holds a real instruction
- id_ex_instr  in  32  instruction; funct=[5:0], shamt=[10:6]
- id_ex_reg1  in  DATA_W  rs value
- id_ex_reg2  in  DATA_W  rt value
- id_ex_imm_value  in  DATA_W  extended immediate
- id_ex_alu_src  in  1  1 selects immediate for ALU operand B
- id_ex_alu_op  in  2  00 add, 01 sub, 10 R-type (decode funct), 11 or
- ex_mem_alu_result  in  DATA_W  forward source from EX/MEM
- mem_wb_write_back_result  in  DATA_W  forward source from MEM/WB
- forward_a  in  2  00 reg1, 01 mem_wb, 10 ex_mem, 11 treated as 00
- forward_b  in  2  same encoding, applied to reg2
- alu_in2_out  out  DATA_W  forwarded rt, before the ALU-source mux (store data)
- alu_result  out  DATA_W  combinational result
- alu_zero  out  1  alu_result == 0
- alu_overflow  out  1  signed overflow on add/sub funct (0x20/0x22) only; no trap
- ex_stall  out  1  hold PC, IF/ID and ID/EX
- mdu_busy  out  1  MDU iterating

Behaviour:
- Combinational path: operand A = fwd_a(reg1); operand B = alu_src ? imm : fwd_b(reg2).
- funct decode when alu_op=10:
  - add/addu 20/21, sub/subu 22/23, and 24, or 25, xor 26, nor 27
  - slt 2A (signed), sltu 2B: result 1 or 0
  - sll 00, srl 02, sra 03: shift operand B by shamt[SH_W-1:0]
  - mfhi 10 -> HI, mflo 12 -> LO
  - mult 18, multu 19, div 1A, divu 1B -> MDU; alu_result = 0
  - any other funct -> alu_result 0
- All arithmetic wraps modulo 2^DATA_W.
- MDU start condition: start_req = id_ex_valid & alu_op==10 & funct in {18,19,1A,1B} & !busy & !done.
- ex_stall = start_req | busy. It is combinational, so it is high in the start cycle itself.
- MDU FSM:
  - IDLE -> RUN on start_req edge. The edge latches forwarded A/B, the op, and the signs.
  - RUN: one radix-2 iteration per cycle, counter 0..DATA_W-1.
  - On the edge ending iteration DATA_W-1: write HI/LO, clear busy, set done, go to DONE.
  - DONE lasts exactly one cycle; ex_stall is low so the pipeline advances. The following edge clears done and returns to IDLE.
- Timing: start in cycle 0 gives ex_stall high in cycles 0..DATA_W (DATA_W+1 cycles). New HI/LO are visible to mfhi/mflo from cycle DATA_W+1.
- mult/multu: {HI,LO} = 2·DATA_W-bit product. Signed ops use the magnitude shift-add product, negated if the operand signs differ.
- div/divu: LO = quotient, HI = remainder, by restoring division on magnitudes.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - min/-1: LO = min, HI = 0.
  - Divide by zero, any signedness: LO = all ones, HI = dividend (raw operand A).
- mfhi/mflo issued while busy never reach EX, because the pipeline is stalled.
- Reset, asserted at any time including mid-RUN:
  - Immediately clears FSM to IDLE, counter, busy, done, HI, LO and operand registers.
  - ex_stall = 0 except through start_req. The aborted operation never writes HI/LO.
  - Combinational outputs follow the inputs regardless of reset.
- id_ex_valid=0 never starts the MDU. It has no effect on the combinational path.

Decomposition:
- Package ex_pkg holds:
  - funct localparams
  - ALU_OP_ADD/SUB/RTYPE/OR
  - FWD_REG/FWD_WB/FWD_MEM
  - MDU op enum {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU}
- One sub-module, mdu_iter (parameter DATA_W). It contains:
  - FSM, counter and operand registers
  - HI/LO
  - start, op, a, b inputs and busy, done, hi, lo outputs
- The top level holds the muxes, ALU, decode and stall logic.

Test Plan:
- Forwarding: reg1=5, ex_mem=9, mem_wb=7; forward_a=10, alu_op=00, alu_src=1, imm=3 -> alu_result=12. forward_a=01 -> 10. forward_a=11 -> 8.
- ALU ops: A=0x80000000, B=1; funct 22 -> 0x7FFFFFFF with alu_overflow=1; slt -> 1; sltu -> 0. sra with shamt=4, B=0x80000000 -> 0xF8000000.
- mult: -3 x 7 -> ex_stall high exactly 33 cycles, then mfhi=0xFFFFFFFF, mflo=0xFFFFFFEB. multu 0xFFFFFFFF x 2 -> HI=1, LO=0xFFFFFFFE.
- div: -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 100/0 -> LO=0xFFFFFFFF, HI=100. div 0x80000000/-1 -> LO=0x80000000, HI=0.
- Reset mid-RUN: start mult 6x7 with HI/LO preloaded to 1/2; reset at iteration 10 -> ex_stall and mdu_busy drop asynchronously, HI=LO=0. A restarted mult completes with LO=42.
- Back-to-back: mult followed by divu in the next ID/EX slot -> the second starts in the cycle after DONE. No spurious restart of the first; total stall 66 cycles.
